event_counter_bank: RTL and testbench

- Bank of NUM_CH independent event counters with one shared clock.
- Each channel has a programmable start value, terminal value, count direction, periodic or one-shot mode, and a tick prescaler.
- Each channel reports a one-cycle terminal pulse, a sticky flag with clear, an overrun indication and a done status.
- Sits beside control/status logic as the general timer/event-count resource for timeouts, rate generation and packet/event budgeting.

---
 rtl/event_counter_bank.sv | 144 ++++++++++++++
 tb/tb_event_counter_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_counter_bank.sv
// rtl/event_counter_bank.sv - bank of independent programmable event counters
//
// Purpose: NUM_CH event counters sharing one clock and one prescale value.
// Each channel has a start value, a terminal value, a direction, a periodic
// or one-shot mode and a tick prescaler. It reports a one-cycle terminal
// pulse, a sticky flag with clear, a sticky overrun and a done status.
//
// Ports:
//   ACLK      clock, rising edge
//   ARESETN   asynchronous active-low reset
//   ENABLE    per-channel count enable (freezes counter/prescaler when low)
//   TICK      per-channel event strobe
//   LOAD      per-channel start/restart, beats any tick in the same cycle
//   MODE      per-channel {down, one_shot}, captured on LOAD
//   INIT_VAL  per-channel start/reload value, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   TARGET    per-channel terminal value, sampled live, same packing
//   PRESCALE  shared divider, one step per PRESCALE+1 qualified ticks
//   CLR_FLAG  per-channel clear of FLAG and OVERRUN
//   COUNTER   per-channel current count, same packing as INIT_VAL
//   REACHED   per-channel registered one-cycle terminal pulse
//   FLAG      per-channel sticky terminal indication
//   OVERRUN   per-channel sticky terminal-while-flagged indication
//   DONE      per-channel one-shot finished (HALT state)
module event_counter_bank #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_CH-1:0]             ENABLE,
  input  logic [NUM_CH-1:0]             TICK,
  input  logic [NUM_CH-1:0]             LOAD,
  input  logic [2*NUM_CH-1:0]           MODE,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   INIT_VAL,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   TARGET,
  input  logic [PRESCALE_WIDTH-1:0]     PRESCALE,
  input  logic [NUM_CH-1:0]             CLR_FLAG,
  output logic [NUM_CH*CNT_WIDTH-1:0]   COUNTER,
  output logic [NUM_CH-1:0]             REACHED,
  output logic [NUM_CH-1:0]             FLAG,
  output logic [NUM_CH-1:0]             OVERRUN,
  output logic [NUM_CH-1:0]             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [1:0]                mode_q, mode_d;
    logic                      reached_q, reached_d;
    logic                      flag_q, flag_d;
    logic                      ovr_q, ovr_d;

    logic tick_qual;
    logic term_hit;

    // LOAD is excluded here so that a restart always wins over a tick.
    assign tick_qual = (state_q == ST_RUN) && ENABLE[i] && TICK[i] && !LOAD[i];
    // Terminal is judged against the count before the step is applied.
    assign term_hit  = tick_qual && (presc_q == PRESCALE) &&
                       (cnt_q == TARGET[i*CNT_WIDTH +: CNT_WIDTH]);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      presc_d   = presc_q;
      mode_d    = mode_q;
      reached_d = term_hit;

      if (LOAD[i]) begin
        cnt_d   = INIT_VAL[i*CNT_WIDTH +: CNT_WIDTH];
        presc_d = '0;
        mode_d  = MODE[2*i +: 2];
        state_d = ST_RUN;
      end else if (tick_qual) begin
        if (presc_q == PRESCALE) begin
          presc_d = '0;
          if (term_hit) begin
            if (mode_q[0]) begin
              state_d = ST_HALT;
            end else begin
              cnt_d = INIT_VAL[i*CNT_WIDTH +: CNT_WIDTH];
            end
          end else if (mode_q[1]) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Wraps naturally if PRESCALE was lowered below the current count.
          presc_d = presc_q + PRESC_ONE;
        end
      end

      // A terminal in the same cycle as a clear keeps FLAG set but records
      // no overrun, since the clear acknowledged the earlier terminal.
      flag_d = term_hit ? 1'b1 : (CLR_FLAG[i] ? 1'b0 : flag_q);
      if (CLR_FLAG[i]) begin
        ovr_d = 1'b0;
      end else if (term_hit && flag_q) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        presc_q   <= '0;
        mode_q    <= '0;
        reached_q <= 1'b0;
        flag_q    <= 1'b0;
        ovr_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        presc_q   <= presc_d;
        mode_q    <= mode_d;
        reached_q <= reached_d;
        flag_q    <= flag_d;
        ovr_q     <= ovr_d;
      end
    end

    assign COUNTER[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    assign REACHED[i] = reached_q;
    assign FLAG[i]    = flag_q;
    assign OVERRUN[i] = ovr_q;
    assign DONE[i]    = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_event_counter_bank.sv
// tb/tb_event_counter_bank.sv - self-checking bench for event_counter_bank
module tb_event_counter_bank;

  localparam int NC   = 4;
  localparam int CW   = 8;
  localparam int PW   = 4;
  localparam int CMOD = 1 << CW;
  localparam int PMOD = 1 << PW;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [NC-1:0]     ENABLE;
  logic [NC-1:0]     TICK;
  logic [NC-1:0]     LOAD;
  logic [2*NC-1:0]   MODE;
  logic [NC*CW-1:0]  INIT_VAL;
  logic [NC*CW-1:0]  TARGET;
  logic [PW-1:0]     PRESCALE;
  logic [NC-1:0]     CLR_FLAG;
  logic [NC*CW-1:0]  COUNTER;
  logic [NC-1:0]     REACHED;
  logic [NC-1:0]     FLAG;
  logic [NC-1:0]     OVERRUN;
  logic [NC-1:0]     DONE;

  event_counter_bank #(.NUM_CH(NC), .CNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE), .TICK(TICK), .LOAD(LOAD),
    .MODE(MODE), .INIT_VAL(INIT_VAL), .TARGET(TARGET), .PRESCALE(PRESCALE),
    .CLR_FLAG(CLR_FLAG), .COUNTER(COUNTER), .REACHED(REACHED), .FLAG(FLAG),
    .OVERRUN(OVERRUN), .DONE(DONE)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int m_cnt   [NC];
  int m_presc [NC];
  int m_mode  [NC];
  int m_st    [NC];
  bit m_rch   [NC];
  bit m_flag  [NC];
  bit m_ovr   [NC];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_presc[c] = 0; m_mode[c] = 0; m_st[c] = M_IDLE;
      m_rch[c] = 0; m_flag[c] = 0; m_ovr[c] = 0;
    end
  endtask

  // One clock edge of the channel rules, evaluated on the inputs present at the edge.
  task automatic model_update();
    for (int c = 0; c < NC; c++) begin
      int ini;
      int tgt;
      bit hit;
      ini = int'(INIT_VAL[c*CW +: CW]);
      tgt = int'(TARGET[c*CW +: CW]);
      hit = 1'b0;
      if (LOAD[c]) begin
        m_cnt[c] = ini; m_presc[c] = 0; m_mode[c] = int'(MODE[2*c +: 2]); m_st[c] = M_RUN;
      end else if (m_st[c] == M_RUN && ENABLE[c] && TICK[c]) begin
        if (m_presc[c] == int'(PRESCALE)) begin
          m_presc[c] = 0;
          if (m_cnt[c] == tgt) begin
            hit = 1'b1;
            if (m_mode[c] % 2 == 1) m_st[c] = M_HALT;
            else m_cnt[c] = ini;
          end else if (m_mode[c] >= 2) begin
            m_cnt[c] = (m_cnt[c] + CMOD - 1) % CMOD;
          end else begin
            m_cnt[c] = (m_cnt[c] + 1) % CMOD;
          end
        end else begin
          m_presc[c] = (m_presc[c] + 1) % PMOD;
        end
      end
      if (CLR_FLAG[c]) m_ovr[c] = 1'b0;
      else if (hit && m_flag[c]) m_ovr[c] = 1'b1;
      if (hit) m_flag[c] = 1'b1;
      else if (CLR_FLAG[c]) m_flag[c] = 1'b0;
      m_rch[c] = hit;
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    if (ARESETN) model_update();
    else model_reset();
    @(negedge ACLK);
  endtask

  always @(negedge ACLK) begin
    if (check_en) begin
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("model_cnt%0d", c), 32'(COUNTER[c*CW +: CW]), 32'(m_cnt[c]));
        chk($sformatf("model_reached%0d", c), 32'(REACHED[c]), 32'(m_rch[c]));
        chk($sformatf("model_flag%0d", c), 32'(FLAG[c]), 32'(m_flag[c]));
        chk($sformatf("model_overrun%0d", c), 32'(OVERRUN[c]), 32'(m_ovr[c]));
        chk($sformatf("model_done%0d", c), 32'(DONE[c]), 32'(m_st[c] == M_HALT));
      end
    end
  end

  task automatic setup_ch(int c, int ini, int tgt, int mode);
    INIT_VAL[c*CW +: CW] = CW'(ini);
    TARGET[c*CW +: CW]   = CW'(tgt);
    MODE[2*c +: 2]       = 2'(mode);
  endtask

  initial begin
    int exp_a [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_b [4] = '{1, 0, 255, 254};
    int pulses [$];
    int rch_cnt;

    ARESETN = 1'b0; ENABLE = '0; TICK = '0; LOAD = '0; MODE = '0;
    INIT_VAL = '0; TARGET = '0; PRESCALE = '0; CLR_FLAG = '0;
    model_reset();
    repeat (2) @(negedge ACLK);
    chk("rst_counter", 32'(COUNTER), 0);
    chk("rst_outputs", 32'({REACHED, FLAG, OVERRUN, DONE}), 0);
    ARESETN = 1'b1;
    check_en = 1'b1;

    // ch0 up periodic 0..3
    setup_ch(0, 0, 3, 0);
    LOAD[0] = 1'b1;
    cyc();
    LOAD[0] = 1'b0; ENABLE[0] = 1'b1; TICK[0] = 1'b1;
    chk("a_load_cnt", 32'(COUNTER[7:0]), 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("a_cnt", 32'(COUNTER[7:0]), 32'(exp_a[k-1]));
      chk("a_reached", 32'(REACHED[0]), 32'(k % 4 == 0));
      if (k == 4) begin
        chk("a_flag_first", 32'(FLAG[0]), 1);
        chk("a_ovr_first", 32'(OVERRUN[0]), 0);
      end
    end
    chk("a_ovr_second", 32'(OVERRUN[0]), 1);
    TICK[0] = 1'b0; ENABLE[0] = 1'b0;

    // ch1 down one-shot 2 -> 254
    setup_ch(1, 2, 254, 3);
    LOAD[1] = 1'b1;
    cyc();
    LOAD[1] = 1'b0; ENABLE[1] = 1'b1; TICK[1] = 1'b1;
    chk("b_load_cnt", 32'(COUNTER[15:8]), 2);
    rch_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k <= 4) chk("b_cnt", 32'(COUNTER[15:8]), 32'(exp_b[k-1]));
      if (REACHED[1]) rch_cnt++;
    end
    chk("b_hold_cnt", 32'(COUNTER[15:8]), 254);
    chk("b_done", 32'(DONE[1]), 1);
    chk("b_single_pulse", 32'(rch_cnt), 1);
    setup_ch(1, 40, 50, 0);
    LOAD[1] = 1'b1;
    cyc();
    LOAD[1] = 1'b0;
    chk("b_reload_done", 32'(DONE[1]), 0);
    chk("b_reload_cnt", 32'(COUNTER[15:8]), 40);
    TICK[1] = 1'b0; ENABLE[1] = 1'b0;

    // ch2 prescaled with an enable gap
    PRESCALE = 4'd2;
    setup_ch(2, 5, 6, 0);
    LOAD[2] = 1'b1;
    cyc();
    LOAD[2] = 1'b0; TICK[2] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      ENABLE[2] = !(c >= 14 && c <= 17);
      cyc();
      if (c == 2) chk("c_cnt_hold", 32'(COUNTER[23:16]), 5);
      if (c == 3) chk("c_cnt_step", 32'(COUNTER[23:16]), 6);
      if (REACHED[2]) pulses.push_back(c);
    end
    chk("c_pulse_count", 32'(pulses.size()), 3);
    if (pulses.size() == 3) begin
      chk("c_pulse0", 32'(pulses[0]), 6);
      chk("c_pulse1", 32'(pulses[1]), 12);
      chk("c_pulse2_stretched", 32'(pulses[2]), 22);
    end
    TICK[2] = 1'b0; ENABLE[2] = 1'b0;

    // ch3 LOAD beats TICK and zeroes the prescaler
    PRESCALE = 4'd1;
    setup_ch(3, 5, 100, 0);
    LOAD[3] = 1'b1;
    cyc();
    LOAD[3] = 1'b0; ENABLE[3] = 1'b1; TICK[3] = 1'b1;
    repeat (4) cyc();
    chk("d_cnt7", 32'(COUNTER[31:24]), 7);
    cyc();
    chk("d_presc_mid", 32'(COUNTER[31:24]), 7);
    INIT_VAL[31:24] = 8'd20; LOAD[3] = 1'b1;
    cyc();
    LOAD[3] = 1'b0;
    chk("d_load_wins", 32'(COUNTER[31:24]), 20);
    cyc();
    chk("d_presc_zeroed", 32'(COUNTER[31:24]), 20);
    cyc();
    chk("d_step_after", 32'(COUNTER[31:24]), 21);

    // ch3 clear racing a terminal
    PRESCALE = 4'd0;
    setup_ch(3, 9, 9, 0);
    LOAD[3] = 1'b1;
    cyc();
    LOAD[3] = 1'b0;
    cyc();
    chk("e_flag_set", 32'(FLAG[3]), 1);
    chk("e_reached", 32'(REACHED[3]), 1);
    CLR_FLAG[3] = 1'b1;
    cyc();
    chk("e_clr_flag_kept", 32'(FLAG[3]), 1);
    chk("e_clr_no_ovr", 32'(OVERRUN[3]), 0);
    CLR_FLAG[3] = 1'b0;
    cyc();
    chk("e_ovr_after", 32'(OVERRUN[3]), 1);
    TICK[3] = 1'b0; CLR_FLAG[3] = 1'b1;
    cyc();
    CLR_FLAG[3] = 1'b0;
    chk("e_clr_flag", 32'(FLAG[3]), 0);
    chk("e_clr_ovr", 32'(OVERRUN[3]), 0);
    ENABLE[3] = 1'b0;

    // asynchronous reset mid-count
    setup_ch(0, 10, 200, 0);
    LOAD[0] = 1'b1;
    cyc();
    LOAD[0] = 1'b0; ENABLE[0] = 1'b1; TICK[0] = 1'b1; CLR_FLAG = '0;
    repeat (3) cyc();
    @(posedge ACLK);
    model_update();
    #3 ARESETN = 1'b0;
    #1;
    chk("r_async_counter", 32'(COUNTER), 0);
    chk("r_async_outputs", 32'({REACHED, FLAG, OVERRUN, DONE}), 0);
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) cyc();
    chk("r_idle_ignores_tick", 32'(COUNTER[7:0]), 0);

    // randomized concurrent operation
    ENABLE = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) begin
        LOAD[c] = ($urandom_range(0, 29) == 0);
        if (LOAD[c]) begin
          MODE[2*c +: 2] = 2'($urandom_range(0, 3));
          INIT_VAL[c*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(240, 255))
                                                              : CW'($urandom_range(0, 20));
        end
        if ($urandom_range(0, 49) == 0)
          TARGET[c*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(240, 255))
                                                           : CW'($urandom_range(0, 20));
        ENABLE[c]   = ($urandom_range(0, 7) != 0);
        TICK[c]     = ($urandom_range(0, 3) != 0);
        CLR_FLAG[c] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 99) == 0) PRESCALE = PW'($urandom_range(0, 5));
      cyc();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
